result_packer: RTL and testbench
================================

RESULT_PACKER -- requirements
Module: result_packer

Interface
- REQ-001 Parameter PACKET_LEN, default 4: result words per output packet; m_axis_tlast marks the last word of each packet; legal range 1..65535.
- REQ-002 Parameter N_CH, default 5: number of CNN result channels; fixed at 5 for this release.
- REQ-003 clk  in  1  single clock; all logic rising-edge.
- REQ-004 reset  in  1  asynchronous, active-high reset.
- REQ-005 s_axis_tvalid  in  [4:0]  per-channel valid of CNN result bytes.
- REQ-006 s_axis_tready  out  [4:0]  per-channel ready.
- REQ-007 s_axis_tdata  in  [7:0] x 5 (unpacked [4:0])  per-channel result byte.
- REQ-008 flush  in  1  single-cycle pulse; forces emission of a partially collected result.
- REQ-009 m_axis_tvalid  out  1  packed-word valid.
- REQ-010 m_axis_tready  in  1  downstream ready.
- REQ-011 m_axis_tdata  out  256  packed result word.
- REQ-012 m_axis_tlast  out  1  last word of packet.
- REQ-013 frame_cnt  out  32  count of words emitted since reset.
- REQ-014 busy  out  1  high when any channel is captured or a word is pending.

Function
- REQ-015 FSM has two states: COLLECT and SEND; reset state is COLLECT.
- REQ-016 COLLECT: s_axis_tready[i] = 1 iff slot i is empty; a handshake on channel i stores the byte in slot i and sets fill bit i; channels are captured independently and in any order.
- REQ-017 COLLECT -> SEND on the cycle after the fill mask becomes 5'h1F; m_axis_tvalid rises exactly 1 cycle after the last capturing handshake.
- REQ-018 SEND: s_axis_tready = 5'b0; m_axis_tvalid = 1; tdata and tlast stay stable until m_axis_tready.
- REQ-019 SEND handshake: clear all slots and fill bits, increment frame_cnt (wraps 0xFFFFFFFF -> 0), advance beat counter, and return to COLLECT next cycle.
- REQ-020 Word layout: [39:0] = {ch4,ch3,ch2,ch1,ch0} bytes, ch0 at [7:0]; [44:40] = fill mask; [45] = flushed flag; [63:46] = 0; [95:64] = frame_cnt value before increment; [127:96] per REQ-031/032; [255:128] = 0.
- REQ-021 Beat counter runs 0..PACKET_LEN-1 and wraps; m_axis_tlast = 1 when beat counter = PACKET_LEN-1, or when the word is flushed.
- REQ-022 Flush in COLLECT with a non-zero fill mask: enter SEND next cycle; emit the partial mask with empty slots at 0x00; set the flushed flag and tlast; reset the beat counter to 0 on handshake.
- REQ-023 Flush in COLLECT with an empty mask, or flush in SEND: ignored.
- REQ-024 A flush coinciding with the handshake that completes the mask: emit a normal full word with the flushed flag = 0; the flush is consumed.
- REQ-025 Data arriving on channel i while slot i is full is back-pressured and never overwritten.
- REQ-026 busy = (fill mask != 0) or (state = SEND).

Reset
- REQ-027 On reset assertion, immediately: state = COLLECT; slots, fill mask, beat counter, frame_cnt, and timestamp registers = 0.
- REQ-028 Output values during reset: m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, s_axis_tready = 5'h1F, busy = 0.
- REQ-029 Reset asserted mid-SEND drops the pending word; no partial word is emitted after release.
- REQ-030 Reset deassertion is synchronised internally by a 2-flop deassert synchroniser.

Configuration
- REQ-031 With RESULT_TIMESTAMP_EN defined: a free-running 32-bit cycle counter (reset 0, wrapping) is latched on the first capture of each word, and the latched value is placed in [127:96].
- REQ-032 Without RESULT_TIMESTAMP_EN: no counter is instantiated and [127:96] = 0.

Verification
- REQ-033 Reset then all five channels valid in one cycle with bytes 0x10..0x14 -> tvalid rises next cycle; [39:0] = 0x1413121110; mask = 0x1F; frame field = 0.
- REQ-034 Channels arrive staggered in order 4,2,0,3,1, one per cycle -> single word, tvalid 1 cycle after ch1; bytes correctly placed.
- REQ-035 PACKET_LEN = 4, 9 full results -> tlast on words 3 and 7 only; frame_cnt = 9.
- REQ-036 Capture ch0 = 0xAA and ch2 = 0xBB, then flush -> mask 0x05, flushed = 1, tlast = 1, other bytes 0; next packet tlast counting restarts at beat 0.
- REQ-037 m_axis_tready held low for 20 cycles in SEND while all s_axis_tvalid are high -> tdata stable, s_axis_tready = 0, no byte lost.
- REQ-038 Reset pulse mid-SEND -> tvalid = 0 immediately; frame_cnt = 0; with RESULT_TIMESTAMP_EN, the timestamp of the first post-reset word equals the cycle of its first capture.

Source files
------------

// File: rtl/result_packer.sv
// rtl/result_packer.sv - gathers five CNN result bytes into one 256-bit stream word
//
// Ports:
//   clk, reset                    clock; asynchronous active-high reset
//   s_axis_tvalid/tready/tdata    per-channel result byte inputs (one slot per channel)
//   flush                         one-cycle pulse, emits a partially filled word
//   m_axis_tvalid/tready/tdata    packed word output
//   m_axis_tlast                  last word of a PACKET_LEN packet, or a flushed word
//   frame_cnt                     words emitted since reset
//   busy                          any slot occupied or a word pending
//
// Optional feature: define RESULT_TIMESTAMP_EN to place a capture timestamp in [127:96].

module result_packer #(
    parameter int PACKET_LEN = 4,
    parameter int N_CH       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  s_axis_tvalid,
    output logic [N_CH-1:0]  s_axis_tready,
    input  logic [7:0]       s_axis_tdata [N_CH],
    input  logic             flush,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [255:0]     m_axis_tdata,
    output logic             m_axis_tlast,
    output logic [31:0]      frame_cnt,
    output logic             busy
);

    localparam logic [N_CH-1:0] LP_ALL  = '1;
    localparam logic [15:0]     LP_LAST = 16'(PACKET_LEN - 1);

    typedef enum logic {COLLECT = 1'b0, SEND = 1'b1} state_t;

    // Reset asserts immediately, releases two clocks after the input drops.
    logic [1:0] r_rst_sync;
    logic       w_rst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rst_sync <= 2'b11;
        else       r_rst_sync <= {r_rst_sync[0], 1'b0};
    end

    assign w_rst = r_rst_sync[1];

    state_t          r_state, w_state_next;
    logic [7:0]      r_slot [N_CH];
    logic [N_CH-1:0] r_fill;
    logic            r_flushed;
    logic [15:0]     r_beat;
    logic [31:0]     r_frame_cnt;
    logic [31:0]     w_ts;

    logic [N_CH-1:0] w_cap;
    logic [N_CH-1:0] w_fill_next;
    logic            w_flush_take;
    logic            w_send_hs;

    assign w_cap        = s_axis_tvalid & s_axis_tready;
    assign w_fill_next  = r_fill | w_cap;
    // A flush only counts when something is already captured; if the same
    // cycle completes the mask the word goes out as a normal full word.
    assign w_flush_take = (r_state == COLLECT) && flush && (r_fill != '0);
    assign w_send_hs    = (r_state == SEND) && m_axis_tready;

    // State register
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) r_state <= COLLECT;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            COLLECT: if (w_fill_next == LP_ALL || w_flush_take) w_state_next = SEND;
            SEND:    if (m_axis_tready)                         w_state_next = COLLECT;
            default: w_state_next = COLLECT;
        endcase
    end

    // Output logic; inputs are held off while the internal reset is still
    // releasing so no byte is accepted that the slots cannot store.
    always_comb begin
        s_axis_tready = '0;
        if (reset)
            s_axis_tready = LP_ALL;
        else if (!w_rst && r_state == COLLECT)
            s_axis_tready = ~r_fill;
        m_axis_tvalid = (r_state == SEND);
        m_axis_tlast  = (r_state == SEND) && ((r_beat == LP_LAST) || r_flushed);
        busy          = (r_fill != '0) || (r_state == SEND);
    end

    // Slots, fill mask, beat and frame counters
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            for (int i = 0; i < N_CH; i++) r_slot[i] <= 8'h00;
            r_fill      <= '0;
            r_flushed   <= 1'b0;
            r_beat      <= 16'h0;
            r_frame_cnt <= 32'h0;
        end else if (r_state == COLLECT) begin
            for (int i = 0; i < N_CH; i++)
                if (w_cap[i]) r_slot[i] <= s_axis_tdata[i];
            r_fill <= w_fill_next;
            if (w_flush_take && w_fill_next != LP_ALL) r_flushed <= 1'b1;
        end else if (w_send_hs) begin
            for (int i = 0; i < N_CH; i++) r_slot[i] <= 8'h00;
            r_fill      <= '0;
            r_flushed   <= 1'b0;
            r_frame_cnt <= r_frame_cnt + 32'd1;
            // A flushed word closes its packet, so the next one starts fresh.
            if (r_flushed || r_beat == LP_LAST) r_beat <= 16'h0;
            else                                r_beat <= r_beat + 16'd1;
        end
    end

`ifdef RESULT_TIMESTAMP_EN
    logic [31:0] r_ts_cnt;
    logic [31:0] r_ts;

    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_ts_cnt <= 32'h0;
            r_ts     <= 32'h0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 32'd1;
            // First byte of a new word marks its timestamp.
            if (r_state == COLLECT && r_fill == '0 && w_cap != '0)
                r_ts <= r_ts_cnt;
        end
    end

    assign w_ts = r_ts;
`else
    assign w_ts = 32'h0;
`endif

    assign m_axis_tdata = {128'h0, w_ts, r_frame_cnt, 18'h0, r_flushed, r_fill,
                           r_slot[4], r_slot[3], r_slot[2], r_slot[1], r_slot[0]};
    assign frame_cnt    = r_frame_cnt;

endmodule

// File: tb/tb_result_packer.sv
// tb/tb_result_packer.sv - directed self-checking bench for result_packer

module tb_result_packer;

    logic         clk = 1'b0;
    logic         reset;
    logic [4:0]   s_tvalid;
    logic [4:0]   s_tready;
    logic [7:0]   s_tdata [5];
    logic         flush;
    logic         m_tvalid;
    logic         m_tready;
    logic [255:0] m_tdata;
    logic         m_tlast;
    logic [31:0]  frame_cnt;
    logic         busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    result_packer #(.PACKET_LEN(4), .N_CH(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .flush         (flush),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .frame_cnt     (frame_cnt),
        .busy          (busy)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] word(input logic [39:0] b, input logic [4:0] m,
                                          input logic f, input logic [31:0] fr);
        return {128'h0, 32'h0, fr, 18'h0, f, m, b};
    endfunction

    task automatic push_all(input logic [7:0] base);
        s_tvalid = 5'h1F;
        for (int i = 0; i < 5; i++) s_tdata[i] = base + 8'(i);
        @(negedge clk);
        s_tvalid = 5'h00;
    endtask

    task automatic pop();
        m_tready = 1'b1;
        @(negedge clk);
        m_tready = 1'b0;
    endtask

    function automatic logic [39:0] bytes_of(input logic [7:0] base);
        return {base + 8'd4, base + 8'd3, base + 8'd2, base + 8'd1, base};
    endfunction

    initial begin
        reset = 1'b1; s_tvalid = 5'h0; flush = 1'b0; m_tready = 1'b0;
        for (int i = 0; i < 5; i++) s_tdata[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_tvalid", 256'(m_tvalid), 256'(1'b0));
        chk("rst_tlast",  256'(m_tlast),  256'(1'b0));
        chk("rst_tdata",  m_tdata,        256'h0);
        chk("rst_tready", 256'(s_tready), 256'(5'h1F));
        chk("rst_busy",   256'(busy),     256'(1'b0));
        chk("rst_frame",  256'(frame_cnt), 256'(32'h0));
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_tready", 256'(s_tready), 256'(5'h1F));

        // All channels in one cycle
        push_all(8'h10);
        chk("all_tvalid", 256'(m_tvalid), 256'(1'b1));
        chk("all_word",   m_tdata, word(40'h1413121110, 5'h1F, 1'b0, 32'd0));
        chk("all_tready", 256'(s_tready), 256'(5'h00));
        chk("all_tlast",  256'(m_tlast), 256'(1'b0));
        pop();
        chk("all_frame", 256'(frame_cnt), 256'(32'd1));
        chk("all_busy",  256'(busy), 256'(1'b0));

        // Staggered arrival 4,2,0,3,1
        begin
            int order [5] = '{4, 2, 0, 3, 1};
            for (int k = 0; k < 5; k++) begin
                s_tvalid = 5'(1 << order[k]);
                s_tdata[order[k]] = 8'hA0 + 8'(order[k]);
                @(negedge clk);
                s_tvalid = 5'h0;
                if (k == 3) begin
                    chk("stag_wait_tvalid", 256'(m_tvalid), 256'(1'b0));
                    chk("stag_wait_busy",   256'(busy), 256'(1'b1));
                end
            end
        end
        chk("stag_tvalid", 256'(m_tvalid), 256'(1'b1));
        chk("stag_word",   m_tdata, word(40'hA4A3A2A1A0, 5'h1F, 1'b0, 32'd1));
        pop();

        // Downstream stall with all inputs pushing
        push_all(8'h20);
        s_tvalid = 5'h1F;
        for (int i = 0; i < 5; i++) s_tdata[i] = 8'h30 + 8'(i);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("stall_tready", 256'(s_tready), 256'(5'h00));
            chk("stall_word",   m_tdata, word(40'h2423222120, 5'h1F, 1'b0, 32'd2));
        end
        chk("stall_tlast", 256'(m_tlast), 256'(1'b0));
        pop();
        @(negedge clk);
        s_tvalid = 5'h0;
        chk("stall_next_tvalid", 256'(m_tvalid), 256'(1'b1));
        chk("stall_next_word",   m_tdata, word(40'h3433323130, 5'h1F, 1'b0, 32'd3));
        chk("stall_next_tlast",  256'(m_tlast), 256'(1'b1));
        pop();
        chk("stall_frame", 256'(frame_cnt), 256'(32'd4));

        // Reset mid-SEND
        push_all(8'h40);
        chk("pre_rst_tvalid", 256'(m_tvalid), 256'(1'b1));
        reset = 1'b1;
        #1;
        chk("midrst_tvalid", 256'(m_tvalid), 256'(1'b0));
        chk("midrst_frame",  256'(frame_cnt), 256'(32'd0));
        chk("midrst_tdata",  m_tdata, 256'h0);
        chk("midrst_tready", 256'(s_tready), 256'(5'h1F));
        chk("midrst_busy",   256'(busy), 256'(1'b0));
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("postrst_tvalid", 256'(m_tvalid), 256'(1'b0));

        // Nine full words, PACKET_LEN 4
        for (int i = 0; i < 9; i++) begin
            push_all(8'(8 * i));
            chk("pkt_word", m_tdata, word(bytes_of(8'(8 * i)), 5'h1F, 1'b0, 32'(i)));
            chk("pkt_tlast", 256'(m_tlast), 256'((i % 4) == 3));
            pop();
        end
        chk("pkt_frame", 256'(frame_cnt), 256'(32'd9));

        // Partial flush of ch0 and ch2
        s_tvalid = 5'b00101;
        for (int i = 0; i < 5; i++) s_tdata[i] = 8'hEE;
        s_tdata[0] = 8'hAA; s_tdata[2] = 8'hBB;
        @(negedge clk);
        s_tvalid = 5'h0;
        chk("part_tvalid", 256'(m_tvalid), 256'(1'b0));
        chk("part_tready", 256'(s_tready), 256'(5'b11010));
        chk("part_busy",   256'(busy), 256'(1'b1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_tvalid", 256'(m_tvalid), 256'(1'b1));
        chk("flush_word",   m_tdata, word(40'h0000BB00AA, 5'h05, 1'b1, 32'd9));
        chk("flush_tlast",  256'(m_tlast), 256'(1'b1));
        pop();
        for (int i = 0; i < 4; i++) begin
            push_all(8'h80);
            chk("after_flush_tlast", 256'(m_tlast), 256'(i == 3));
            pop();
        end
        chk("after_flush_frame", 256'(frame_cnt), 256'(32'd14));

        // Flush with nothing captured
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("empty_flush_tvalid", 256'(m_tvalid), 256'(1'b0));
        @(negedge clk);
        chk("empty_flush_busy", 256'(busy), 256'(1'b0));

        // Flush together with the completing capture
        flush = 1'b1;
        push_all(8'h60);
        flush = 1'b0;
        chk("co_flush_word",  m_tdata, word(40'h6463626160, 5'h1F, 1'b0, 32'd14));
        chk("co_flush_tlast", 256'(m_tlast), 256'(1'b0));
        pop();

        // Full slot is not overwritten
        s_tvalid = 5'b00001; s_tdata[0] = 8'h11;
        @(negedge clk);
        s_tdata[0] = 8'h99;
        chk("hold_tready", 256'(s_tready), 256'(5'h1E));
        s_tvalid = 5'h1F;
        for (int i = 1; i < 5; i++) s_tdata[i] = 8'h70 + 8'(i);
        @(negedge clk);
        s_tvalid = 5'h0;
        chk("hold_word", m_tdata, word(40'h7473727111, 5'h1F, 1'b0, 32'd15));
        pop();
        chk("final_frame", 256'(frame_cnt), 256'(32'd16));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
